// File: rtl/draw_cmd_sequencer.sv
// Display-list sequencer: pops DRAWCMD words, keeps frame/area/colour state, clips PATBLT and issues one job at a time.
// Optional feature macro DRAW_SEQ_IRQ_EN: level irq on EODL completion and on a bad opcode (otherwise irq is tied 0).
module draw_cmd_sequencer #(
  parameter int CW = 16,
  parameter int AW = 32
) (
  input  logic          ACLK,
  input  logic          ARESET,
  input  logic          start,
  input  logic          clr,
  input  logic          cmd_empty,
  input  logic [31:0]   cmd_rdata,
  output logic          cmd_rden,
  output logic          blt_valid,
  input  logic          blt_ready,
  output logic [AW-1:0] blt_base,
  output logic [CW-1:0] blt_fw,
  output logic [CW-1:0] blt_x,
  output logic [CW-1:0] blt_y,
  output logic [CW-1:0] blt_w,
  output logic [CW-1:0] blt_h,
  output logic [23:0]   blt_color,
  input  logic          blt_done,
  output logic          busy,
  output logic          err,
  output logic          irq,
  input  logic          irq_clr
);

  localparam logic [7:0] OP_SETFRAME  = 8'h20;
  localparam logic [7:0] OP_SETAREA   = 8'h21;
  localparam logic [7:0] OP_SETFCOLOR = 8'h23;
  localparam logic [7:0] OP_PATBLT    = 8'h81;
  localparam logic [7:0] OP_EODL      = 8'h0F;

  typedef enum logic [2:0] {S_IDLE, S_OP, S_ARG, S_EXEC, S_ISSUE, S_WAIT} state_t;

  state_t        state_q, state_d;
  logic [7:0]    op_q, op_d;
  logic          arg_idx_q, arg_idx_d;
  logic [31:0]   arg0_q, arg0_d;
  logic [AW-1:0] base_q, base_d;
  logic [CW-1:0] fw_q, fw_d, fh_q, fh_d;
  logic [CW-1:0] ax_q, ax_d, ay_q, ay_d, aw_q, aw_d, ah_q, ah_d;
  logic [CW-1:0] pw_q, pw_d, ph_q, ph_d;
  logic [CW-1:0] bx_q, bx_d, by_q, by_d, bw_q, bw_d, bh_q, bh_d;
  logic [23:0]   color_q, color_d;
  logic          err_q, err_d;
  logic          irq_set;

  function automatic logic [CW:0] umax(input logic [CW:0] a, input logic [CW:0] b);
    return (a > b) ? a : b;
  endfunction

  function automatic logic [CW:0] umin(input logic [CW:0] a, input logic [CW:0] b);
    return (a < b) ? a : b;
  endfunction

  // One extra bit so px+pw and ax+aw never wrap before clipping.
  logic [CW:0] px, py, x0, x1, y0, y1, xw, yw;
  logic        clip_empty;

  always_comb begin
    px = {1'b0, arg0_q[16 +: CW]};
    py = {1'b0, arg0_q[0 +: CW]};
    x0 = umax(px, {1'b0, ax_q});
    y0 = umax(py, {1'b0, ay_q});
    x1 = umin(umin(px + {1'b0, pw_q}, {1'b0, ax_q} + {1'b0, aw_q}), {1'b0, fw_q});
    y1 = umin(umin(py + {1'b0, ph_q}, {1'b0, ay_q} + {1'b0, ah_q}), {1'b0, fh_q});
    xw = x1 - x0;
    yw = y1 - y0;
    clip_empty = (x1 <= x0) || (y1 <= y0);
  end

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    arg_idx_d = arg_idx_q;
    arg0_d    = arg0_q;
    base_d    = base_q;
    fw_d      = fw_q;
    fh_d      = fh_q;
    ax_d      = ax_q;
    ay_d      = ay_q;
    aw_d      = aw_q;
    ah_d      = ah_q;
    pw_d      = pw_q;
    ph_d      = ph_q;
    bx_d      = bx_q;
    by_d      = by_q;
    bw_d      = bw_q;
    bh_d      = bh_q;
    color_d   = color_q;
    err_d     = err_q;
    irq_set   = 1'b0;
    cmd_rden  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_OP;
      end
      S_OP: begin
        cmd_rden = !cmd_empty;
        if (!cmd_empty) begin
          op_d      = cmd_rdata[31:24];
          arg_idx_d = 1'b0;
          case (cmd_rdata[31:24])
            OP_SETFRAME, OP_SETAREA, OP_SETFCOLOR, OP_PATBLT: state_d = S_ARG;
            OP_EODL: begin
              state_d = S_IDLE;
              irq_set = 1'b1;
            end
            default: begin
              state_d = S_IDLE;
              err_d   = 1'b1;
              irq_set = 1'b1;
            end
          endcase
        end
      end
      S_ARG: begin
        cmd_rden = !cmd_empty;
        if (!cmd_empty) begin
          if (!arg_idx_q && (op_q != OP_SETFCOLOR)) begin
            arg0_d    = cmd_rdata;
            arg_idx_d = 1'b1;
          end else begin
            state_d = S_OP;
            case (op_q)
              OP_SETFRAME: begin
                base_d = arg0_q[AW-1:0];
                fw_d   = cmd_rdata[16 +: CW];
                fh_d   = cmd_rdata[0 +: CW];
              end
              OP_SETAREA: begin
                ax_d = arg0_q[16 +: CW];
                ay_d = arg0_q[0 +: CW];
                aw_d = cmd_rdata[16 +: CW];
                ah_d = cmd_rdata[0 +: CW];
              end
              OP_SETFCOLOR: color_d = cmd_rdata[23:0];
              default: begin
                pw_d    = cmd_rdata[16 +: CW];
                ph_d    = cmd_rdata[0 +: CW];
                state_d = S_EXEC;
              end
            endcase
          end
        end
      end
      S_EXEC: begin
        if (clip_empty) begin
          state_d = S_OP;
        end else begin
          bx_d    = x0[CW-1:0];
          by_d    = y0[CW-1:0];
          bw_d    = xw[CW-1:0];
          bh_d    = yw[CW-1:0];
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (blt_ready) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (blt_done) state_d = S_OP;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // clr is a soft reset with the same reach as ARESET.
  always_ff @(posedge ACLK) begin
    if (ARESET || clr) begin
      state_q   <= S_IDLE;
      op_q      <= '0;
      arg_idx_q <= 1'b0;
      arg0_q    <= '0;
      base_q    <= '0;
      fw_q      <= '0;
      fh_q      <= '0;
      ax_q      <= '0;
      ay_q      <= '0;
      aw_q      <= '0;
      ah_q      <= '0;
      pw_q      <= '0;
      ph_q      <= '0;
      bx_q      <= '0;
      by_q      <= '0;
      bw_q      <= '0;
      bh_q      <= '0;
      color_q   <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      arg_idx_q <= arg_idx_d;
      arg0_q    <= arg0_d;
      base_q    <= base_d;
      fw_q      <= fw_d;
      fh_q      <= fh_d;
      ax_q      <= ax_d;
      ay_q      <= ay_d;
      aw_q      <= aw_d;
      ah_q      <= ah_d;
      pw_q      <= pw_d;
      ph_q      <= ph_d;
      bx_q      <= bx_d;
      by_q      <= by_d;
      bw_q      <= bw_d;
      bh_q      <= bh_d;
      color_q   <= color_d;
      err_q     <= err_d;
    end
  end

  assign blt_valid = (state_q == S_ISSUE);
  assign busy      = (state_q != S_IDLE);
  assign err       = err_q;
  assign blt_base  = base_q;
  assign blt_fw    = fw_q;
  assign blt_x     = bx_q;
  assign blt_y     = by_q;
  assign blt_w     = bw_q;
  assign blt_h     = bh_q;
  assign blt_color = color_q;

  logic unused_diff_msb;
  assign unused_diff_msb = xw[CW] ^ yw[CW];

`ifdef DRAW_SEQ_IRQ_EN
  logic irq_q;
  // A new event wins over a simultaneous irq_clr.
  always_ff @(posedge ACLK) begin
    if (ARESET || clr) irq_q <= 1'b0;
    else if (irq_set)  irq_q <= 1'b1;
    else if (irq_clr)  irq_q <= 1'b0;
  end
  assign irq = irq_q;
`else
  logic unused_irq;
  assign unused_irq = irq_clr ^ irq_set;
  assign irq = 1'b0;
`endif

endmodule

// File: tb/tb_draw_cmd_sequencer.sv
// Scoreboard bench for draw_cmd_sequencer: list-level reference model, FWFT FIFO and pixel-writer models.
`timescale 1ns/1ps
module tb_draw_cmd_sequencer;

  logic        ACLK = 1'b0;
  logic        ARESET = 1'b1;
  logic        start = 1'b0;
  logic        clr = 1'b0;
  logic        cmd_empty = 1'b1;
  logic [31:0] cmd_rdata = 32'h0;
  logic        cmd_rden;
  logic        blt_valid;
  logic        blt_ready = 1'b0;
  logic [31:0] blt_base;
  logic [15:0] blt_fw, blt_x, blt_y, blt_w, blt_h;
  logic [23:0] blt_color;
  logic        blt_done = 1'b0;
  logic        busy, err, irq;
  logic        irq_clr = 1'b0;

  draw_cmd_sequencer #(.CW(16), .AW(32)) dut (
    .ACLK(ACLK), .ARESET(ARESET), .start(start), .clr(clr),
    .cmd_empty(cmd_empty), .cmd_rdata(cmd_rdata), .cmd_rden(cmd_rden),
    .blt_valid(blt_valid), .blt_ready(blt_ready), .blt_base(blt_base), .blt_fw(blt_fw),
    .blt_x(blt_x), .blt_y(blt_y), .blt_w(blt_w), .blt_h(blt_h), .blt_color(blt_color),
    .blt_done(blt_done), .busy(busy), .err(err), .irq(irq), .irq_clr(irq_clr)
  );

  always #5 ACLK = ~ACLK;

  typedef struct packed {
    logic [31:0] base;
    logic [15:0] fw, x, y, w, h;
    logic [23:0] color;
  } job_t;

  job_t        exp_q[$];
  logic [31:0] fifo[$], backlog[$], list_q[$];
  int          pop_log[$], rise_log[$];
  int          checks = 0, errors = 0, ncyc = 0, pw_cnt = 0;
  bit          pop_pend = 0, pw_hold = 0, rand_feed = 0, rand_ready = 0;

  logic [31:0] m_base = 0;
  logic [23:0] m_color = 0;
  int          m_fw = 0, m_fh = 0, m_ax = 0, m_ay = 0, m_aw = 0, m_ah = 0;

  task automatic chk(input string name, input logic [159:0] act, input logic [159:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, req, ncyc);
    end
  endtask

  // FIFO feeder, ready generator and pixel writer; the DUT's requests are sampled mid-cycle.
  always @(negedge ACLK) begin
    ncyc++;
    if (pop_pend && fifo.size() > 0) void'(fifo.pop_front());
    if (rand_feed) begin
      if (backlog.size() > 0 && $urandom_range(0, 2) == 0) fifo.push_back(backlog.pop_front());
    end else begin
      while (backlog.size() > 0) fifo.push_back(backlog.pop_front());
    end
    blt_ready = rand_ready ? ($urandom_range(0, 2) != 0) : 1'b1;
    blt_done = 1'b0;
    if (pw_cnt > 0) begin
      pw_cnt--;
      if (pw_cnt == 0) blt_done = 1'b1;
    end
    #1;
    if (clr) begin
      pw_cnt = 0;
      blt_done = 1'b0;
    end
    cmd_empty = (fifo.size() == 0);
    cmd_rdata = cmd_empty ? 32'h0 : fifo[0];
    #1;
    pop_pend = cmd_rden && !cmd_empty;
    if (pop_pend) pop_log.push_back(ncyc);
    if (blt_valid && blt_ready) pw_cnt = pw_hold ? 100000 : int'($urandom_range(1, 4));
  end

  // Monitor: job scoreboard, stall stability, no pop from an empty FIFO.
  job_t cur, prev_job, expj;
  bit   prev_stall = 0, prev_valid = 0;
  always @(negedge ACLK) begin
    #3;
    cur = {blt_base, blt_fw, blt_x, blt_y, blt_w, blt_h, blt_color};
    if (cmd_rden) chk("pop_while_empty", {159'h0, cmd_empty}, 160'h0);
    if (prev_stall) begin
      checks++;
      if (!blt_valid || cur !== prev_job) begin
        errors++;
        $display("FAIL stall_stable: valid=%0b job=%h required valid=1 job=%h", blt_valid, cur, prev_job);
      end
    end
    if (blt_valid && !prev_valid) rise_log.push_back(ncyc);
    if (blt_valid && blt_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_job: got %h required no job", cur);
      end else begin
        expj = exp_q.pop_front();
        if (cur !== expj) begin
          errors++;
          $display("FAIL job: got base=%h fw=%0d x=%0d y=%0d w=%0d h=%0d col=%h required base=%h fw=%0d x=%0d y=%0d w=%0d h=%0d col=%h",
                   cur.base, cur.fw, cur.x, cur.y, cur.w, cur.h, cur.color,
                   expj.base, expj.fw, expj.x, expj.y, expj.w, expj.h, expj.color);
        end
      end
    end
    prev_stall = blt_valid && !blt_ready;
    prev_job   = cur;
    prev_valid = blt_valid;
  end

  function automatic logic [31:0] xy(input int x, input int y);
    return {x[15:0], y[15:0]};
  endfunction

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  function automatic int imin(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  task automatic cmd0(input logic [7:0] op);
    list_q.push_back({op, 24'h0});
  endtask

  task automatic cmd1(input logic [7:0] op, input logic [31:0] a);
    list_q.push_back({op, 24'h0});
    list_q.push_back(a);
  endtask

  task automatic cmd2(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b);
    list_q.push_back({op, 24'h0});
    list_q.push_back(a);
    list_q.push_back(b);
  endtask

  task automatic model_reset();
    m_base = 0; m_color = 0;
    m_fw = 0; m_fh = 0; m_ax = 0; m_ay = 0; m_aw = 0; m_ah = 0;
  endtask

  // Walks the whole list: updates state, clips each rectangle, queues expected jobs.
  task automatic run_model(output bit m_err, output int used);
    int i, px, py, pw, ph, x0, x1, y0, y1;
    logic [7:0] op;
    job_t j;
    m_err = 0;
    i = 0;
    used = list_q.size();
    while (i < list_q.size()) begin
      op = list_q[i][31:24];
      i++;
      if (op == 8'h20) begin
        m_base = list_q[i];
        m_fw = int'(list_q[i+1][31:16]);
        m_fh = int'(list_q[i+1][15:0]);
        i += 2;
      end else if (op == 8'h21) begin
        m_ax = int'(list_q[i][31:16]);   m_ay = int'(list_q[i][15:0]);
        m_aw = int'(list_q[i+1][31:16]); m_ah = int'(list_q[i+1][15:0]);
        i += 2;
      end else if (op == 8'h23) begin
        m_color = list_q[i][23:0];
        i += 1;
      end else if (op == 8'h81) begin
        px = int'(list_q[i][31:16]);   py = int'(list_q[i][15:0]);
        pw = int'(list_q[i+1][31:16]); ph = int'(list_q[i+1][15:0]);
        i += 2;
        x0 = imax(px, m_ax);
        y0 = imax(py, m_ay);
        x1 = imin(imin(px + pw, m_ax + m_aw), m_fw);
        y1 = imin(imin(py + ph, m_ay + m_ah), m_fh);
        if (x1 > x0 && y1 > y0) begin
          j.base = m_base; j.fw = 16'(m_fw); j.color = m_color;
          j.x = 16'(x0); j.y = 16'(y0); j.w = 16'(x1 - x0); j.h = 16'(y1 - y0);
          exp_q.push_back(j);
        end
      end else if (op == 8'h0F) begin
        used = i;
        break;
      end else begin
        m_err = 1;
        used = i;
        break;
      end
    end
  endtask

  task automatic do_clr();
    @(negedge ACLK);
    clr = 1'b1;
    @(negedge ACLK);
    clr = 1'b0;
    fifo.delete();
    backlog.delete();
    model_reset();
    #4;
    chk("clr_busy", {159'h0, busy}, 160'h0);
    chk("clr_err", {159'h0, err}, 160'h0);
    chk("clr_irq", {159'h0, irq}, 160'h0);
    chk("clr_valid", {159'h0, blt_valid}, 160'h0);
    chk("clr_outputs", {blt_base, blt_fw, blt_x, blt_y, blt_w, blt_h, blt_color}, 160'h0);
  endtask

  task automatic run_list(input bit check_lat);
    bit m_err;
    int used, t;
    run_model(m_err, used);
    pop_log.delete();
    rise_log.delete();
    @(negedge ACLK);
    foreach (list_q[i]) backlog.push_back(list_q[i]);
    start = 1'b1;
    @(negedge ACLK);
    start = 1'b0;
    #4;
    chk("busy_rise", {159'h0, busy}, 160'h1);
    t = 0;
    while (busy === 1'b1 && t < 3000) begin
      @(negedge ACLK);
      #4;
      t++;
    end
    chk("busy_fall", {159'h0, busy}, 160'h0);
`ifdef DRAW_SEQ_IRQ_EN
    chk("irq_set", {159'h0, irq}, 160'h1);
`endif
    chk("err", {159'h0, err}, {159'h0, m_err});
    repeat (2) @(negedge ACLK);
    #4;
    chk("words_left", 160'(fifo.size() + backlog.size()), 160'(list_q.size() - used));
    chk("jobs_missing", 160'(exp_q.size()), 160'h0);
    exp_q.delete();
    if (check_lat) begin
      if (rise_log.size() >= 1 && pop_log.size() >= 11)
        chk("patblt_latency", 160'(rise_log[0] - pop_log[10]), 160'd2);
      else
        chk("patblt_latency_seen", 160'(rise_log.size()), 160'd1);
    end
    if (m_err) begin
      do_clr();
    end else begin
`ifdef DRAW_SEQ_IRQ_EN
      @(negedge ACLK);
      irq_clr = 1'b1;
      @(negedge ACLK);
      irq_clr = 1'b0;
      #4;
      chk("irq_clr", {159'h0, irq}, 160'h0);
`else
      chk("irq_tied", {159'h0, irq}, 160'h0);
`endif
    end
    list_q.delete();
  endtask

  task automatic gen_random(input bit with_bad);
    int n, k;
    logic [7:0] bad_ops [4];
    bad_ops = '{8'h55, 8'h00, 8'h22, 8'hFF};
    n = int'($urandom_range(2, 4));
    if ($urandom_range(0, 1) == 1)
      cmd2(8'h20, $urandom, xy(int'($urandom_range(1, 800)), int'($urandom_range(1, 600))));
    if ($urandom_range(0, 1) == 1)
      cmd2(8'h21, xy(int'($urandom_range(0, 400)), int'($urandom_range(0, 300))),
                  xy(int'($urandom_range(0, 700)), int'($urandom_range(0, 500))));
    if ($urandom_range(0, 1) == 1) cmd1(8'h23, $urandom);
    for (int i = 0; i < n; i++) begin
      if (with_bad && i == 1) begin
        k = int'($urandom_range(0, 3));
        cmd0(bad_ops[k]);
      end
      if ($urandom_range(0, 7) == 0)
        cmd2(8'h81, xy(int'($urandom_range(65000, 65535)), int'($urandom_range(0, 100))),
                    xy(65535, int'($urandom_range(0, 300))));
      else
        cmd2(8'h81, xy(int'($urandom_range(0, 900)), int'($urandom_range(0, 650))),
                    xy(int'($urandom_range(0, 600)), int'($urandom_range(0, 450))));
    end
    cmd0(8'h0F);
  endtask

  task automatic list_full_frame();
    cmd2(8'h20, 32'h2000_0000, xy(640, 480));
    cmd2(8'h21, xy(0, 0), xy(640, 480));
    cmd1(8'h23, 32'h00FF_0000);
    cmd2(8'h81, xy(0, 0), xy(640, 480));
    cmd0(8'h0F);
  endtask

  initial begin
    bit dmy_err;
    int dmy_used, t;

    repeat (3) @(negedge ACLK);
    #4;
    chk("rst_busy", {159'h0, busy}, 160'h0);
    chk("rst_err", {159'h0, err}, 160'h0);
    chk("rst_irq", {159'h0, irq}, 160'h0);
    chk("rst_valid", {159'h0, blt_valid}, 160'h0);
    chk("rst_rden", {159'h0, cmd_rden}, 160'h0);
    chk("rst_outputs", {blt_base, blt_fw, blt_x, blt_y, blt_w, blt_h, blt_color}, 160'h0);
    @(negedge ACLK);
    ARESET = 1'b0;

    // Full-frame fill with latency measurement.
    list_full_frame();
    run_list(1);

    // Draw area smaller than the rectangle.
    cmd2(8'h21, xy(160, 120), xy(320, 240));
    cmd2(8'h81, xy(0, 0), xy(640, 480));
    cmd0(8'h0F);
    run_list(0);

    // Clipping at the frame edge, fully outside, then a normal one.
    cmd2(8'h21, xy(0, 0), xy(640, 480));
    cmd2(8'h81, xy(480, 360), xy(320, 240));
    cmd2(8'h81, xy(700, 0), xy(10, 10));
    cmd2(8'h81, xy(1, 2), xy(3, 4));
    cmd0(8'h0F);
    run_list(0);

    // Unknown opcode mid-list.
    cmd1(8'h23, 32'h0012_3456);
    cmd0(8'h55);
    cmd2(8'h81, xy(0, 0), xy(8, 8));
    run_list(0);

    // Random lists with a starving FIFO and random ready.
    rand_feed = 1;
    rand_ready = 1;
    for (int r = 0; r < 14; r++) begin
      gen_random($urandom_range(0, 4) == 0);
      run_list(0);
    end
    rand_feed = 0;
    rand_ready = 0;

    // clr while waiting for blt_done abandons the job; a fresh list then runs normally.
    cmd2(8'h20, 32'h1000_0000, xy(320, 200));
    cmd2(8'h21, xy(0, 0), xy(320, 200));
    cmd2(8'h81, xy(10, 10), xy(5, 5));
    cmd0(8'h0F);
    run_model(dmy_err, dmy_used);
    pw_hold = 1;
    @(negedge ACLK);
    foreach (list_q[i]) backlog.push_back(list_q[i]);
    list_q.delete();
    start = 1'b1;
    @(negedge ACLK);
    start = 1'b0;
    t = 0;
    while (exp_q.size() != 0 && t < 500) begin
      @(negedge ACLK);
      t++;
    end
    chk("wait_job_issued", 160'(exp_q.size()), 160'h0);
    repeat (3) @(negedge ACLK);
    #4;
    chk("wait_busy", {159'h0, busy}, 160'h1);
    do_clr();
    pw_hold = 0;
    list_full_frame();
    run_list(0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
